// File: rtl/memory_access_if.sv
// memory_access_if: bundles every signal of the memory_access stage except the
// clock and reset.
//
// Signal groups:
//   execute -> stage  : in_valid, in_ready, instruction, alu_result, store_data
//   stage <-> memory  : mem_req, mem_we, mem_addr, mem_wdata, mem_ack, mem_rdata
//   stage -> wb       : out_valid, instruction_out, in_out, memory_in, fault
//   debug             : dbg_state (current FSM state)
//
// Modports:
//   slave  - the memory_access stage itself.
//   master - the environment: execute, data memory and write-back.
//
// Handshakes:
//   Upstream  : a transfer happens on a rising clock edge where in_valid and
//               in_ready are both 1. in_ready does not depend on in_valid.
//   Memory    : mem_req rises with mem_addr/mem_we/mem_wdata valid. These stay
//               stable until the memory answers with a one-cycle mem_ack, with
//               mem_rdata valid in that same cycle. mem_ack is ignored while
//               mem_req is 0.
//   Downstream: out_valid is a one-cycle pulse per transaction. There is no
//               ready; write-back always accepts.
interface memory_access_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] instruction;
  logic [DATA_WIDTH-1:0] alu_result;
  logic [DATA_WIDTH-1:0] store_data;
  logic                  mem_req;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] instruction_out;
  logic [DATA_WIDTH-1:0] in_out;
  logic [DATA_WIDTH-1:0] memory_in;
  logic                  fault;
  logic [1:0]            dbg_state;

  modport slave (
    input  in_valid, instruction, alu_result, store_data, mem_ack, mem_rdata,
    output in_ready, mem_req, mem_we, mem_addr, mem_wdata,
           out_valid, instruction_out, in_out, memory_in, fault, dbg_state
  );

  modport master (
    output in_valid, instruction, alu_result, store_data, mem_ack, mem_rdata,
    input  in_ready, mem_req, mem_we, mem_addr, mem_wdata,
           out_valid, instruction_out, in_out, memory_in, fault, dbg_state
  );
endinterface

// File: rtl/memory_access.sv
// memory_access: the pipeline stage that sits just before write-back.
//
// Pass-through instructions reach write-back after 1 cycle. For LW (opcode 0)
// and SW (opcode 1) the stage runs a req/ack access on the data memory. A
// watchdog aborts the access after TIMEOUT_CYCLES cycles without an ack and
// sets a sticky fault flag.
//
// Ports:
//   clock - rising-edge stage clock
//   reset - asynchronous, active-low reset
//   bus   - memory_access_if.slave (execute, memory and write-back signals)
module memory_access #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic            clock,
  input  logic            reset,
  memory_access_if.slave  bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [4:0] OP_LW = 5'd0;
  localparam logic [4:0] OP_SW = 5'd1;

  // One extra bit of headroom keeps the width at 1 or more when TIMEOUT_CYCLES is 1.
  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]            r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_instr;
  logic                  r_mem_req;
  logic                  r_mem_we;
  logic [DATA_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_instruction_out;
  logic [DATA_WIDTH-1:0] r_in_out;
  logic [DATA_WIDTH-1:0] r_memory_in;
  logic                  r_fault;

  logic [4:0] w_opcode;
  logic       w_accept;
  logic       w_is_mem;

  assign w_opcode = bus.instruction[DATA_WIDTH-1 -: 5];
  assign w_is_mem = (w_opcode == OP_LW) || (w_opcode == OP_SW);
  assign w_accept = bus.in_valid && (r_state == S_IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state           <= S_IDLE;
      r_cnt             <= '0;
      r_instr           <= '0;
      r_mem_req         <= 1'b0;
      r_mem_we          <= 1'b0;
      r_mem_addr        <= '0;
      r_mem_wdata       <= '0;
      r_out_valid       <= 1'b0;
      r_instruction_out <= '0;
      r_in_out          <= '0;
      r_memory_in       <= '0;
      r_fault           <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_is_mem) begin
              r_instr     <= bus.instruction;
              r_mem_req   <= 1'b1;
              r_mem_addr  <= bus.alu_result;
              r_mem_we    <= (w_opcode == OP_SW);
              r_mem_wdata <= (w_opcode == OP_SW) ? bus.store_data : '0;
              r_cnt       <= '0;
              r_state     <= S_ACCESS;
            end else begin
              r_out_valid       <= 1'b1;
              r_instruction_out <= bus.instruction;
              r_in_out          <= bus.alu_result;
              r_memory_in       <= '0;
            end
          end
        end
        S_ACCESS: begin
          // An ack in the last watchdog cycle is tested first, so it wins over the timeout.
          if (bus.mem_ack) begin
            r_mem_req         <= 1'b0;
            // For SW, write-back sees the value that was stored. mem_wdata still holds it.
            r_memory_in       <= r_mem_we ? r_mem_wdata : bus.mem_rdata;
            r_out_valid       <= 1'b1;
            r_instruction_out <= r_instr;
            r_in_out          <= r_mem_addr;
            r_state           <= S_DONE;
          end else if (r_cnt == CNT_LAST) begin
            r_mem_req         <= 1'b0;
            r_fault           <= 1'b1;
            r_memory_in       <= '0;
            r_out_valid       <= 1'b1;
            r_instruction_out <= r_instr;
            r_in_out          <= r_mem_addr;
            r_state           <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready        = (r_state == S_IDLE);
  assign bus.mem_req         = r_mem_req;
  assign bus.mem_we          = r_mem_we;
  assign bus.mem_addr        = r_mem_addr;
  assign bus.mem_wdata       = r_mem_wdata;
  assign bus.out_valid       = r_out_valid;
  assign bus.instruction_out = r_instruction_out;
  assign bus.in_out          = r_in_out;
  assign bus.memory_in       = r_memory_in;
  assign bus.fault           = r_fault;
  assign bus.dbg_state       = r_state;

endmodule

// File: tb/tb_memory_access.sv
// tb_memory_access: testbench for memory_access.
// It uses a table of pass-through vectors and hand-written memory sequences.
// It ends with a mixed stream checked against an in-order expected queue.
module tb_memory_access;

  localparam int W  = 32;
  localparam int TO = 16;

  logic clk;
  logic rst_n;

  memory_access_if #(.DATA_WIDTH(W)) bus ();

  memory_access #(.DATA_WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [3*W-1:0] exp_q[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.in_valid    = 1'b0;
    bus.instruction = '0;
    bus.alu_result  = '0;
    bus.store_data  = '0;
    bus.mem_ack     = 1'b0;
    bus.mem_rdata   = '0;
  endtask

  // ---------------- driver: one LW/SW access ----------------
  // ack_at = 0 means the memory never answers.
  task automatic mem_op(input string name, input logic [W-1:0] instr, input logic [W-1:0] alu,
                        input logic [W-1:0] sd, input int ack_at, input logic [W-1:0] rdata,
                        input int exp_n, input logic [W-1:0] exp_mem_in, input logic exp_fault);
    int n;
    logic is_sw;
    logic ok;
    is_sw = (instr[31:27] == 5'd1);
    @(negedge clk);
    check({name, "_ready_idle"}, {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid    = 1'b1;
    bus.instruction = instr;
    bus.alu_result  = alu;
    bus.store_data  = sd;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.store_data = 32'h0BAD_0BAD;
    n = 0;
    while (bus.mem_req && n < 40) begin
      n++;
      bus.mem_ack = 1'b0;
      ok = (bus.mem_addr === alu) && (bus.mem_we === is_sw) &&
           (bus.mem_wdata === (is_sw ? sd : 32'd0)) && (bus.in_ready === 1'b0) &&
           (bus.out_valid === 1'b0);
      check({name, "_hold"}, {31'd0, ok}, 32'd1);
      if (n == ack_at) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = rdata;
      end
      @(negedge clk);
    end
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'hFFFF_FFFF;
    check({name, "_req_cycles"}, n, exp_n);
    check({name, "_out_valid"}, {31'd0, bus.out_valid}, 32'd1);
    check({name, "_memory_in"}, bus.memory_in, exp_mem_in);
    check({name, "_instr_out"}, bus.instruction_out, instr);
    check({name, "_in_out"}, bus.in_out, alu);
    check({name, "_fault"}, {31'd0, bus.fault}, {31'd0, exp_fault});
    check({name, "_ready_done"}, {31'd0, bus.in_ready}, 32'd0);
    @(negedge clk);
    check({name, "_pulse_end"}, {31'd0, bus.out_valid}, 32'd0);
    check({name, "_ready_back"}, {31'd0, bus.in_ready}, 32'd1);
  endtask

  // ---------------- pass-through vector table ----------------
  typedef struct {
    logic [W-1:0] instr;
    logic [W-1:0] alu;
    logic [W-1:0] exp_instr_out;
    logic [W-1:0] exp_in_out;
    logic [W-1:0] exp_mem_in;
  } vec_t;

  vec_t vecs[6];

  int ops[23] = '{2, 0, 3, 4, 1, 5, 6, 7, 0, 8, 9, 10, 1, 11, 12, 13, 14, 0, 15, 16, 1, 17, 18};
  localparam logic [W-1:0] RK = 32'h5A5A_0000;

  initial begin
    vecs[0] = '{32'h2800_0000, 32'hDEAD_BEEF, 32'h2800_0000, 32'hDEAD_BEEF, 32'h0};
    vecs[1] = '{32'h1000_0001, 32'h0000_0000, 32'h1000_0001, 32'h0000_0000, 32'h0};
    vecs[2] = '{32'hF800_1234, 32'hFFFF_FFFF, 32'hF800_1234, 32'hFFFF_FFFF, 32'h0};
    vecs[3] = '{32'h1800_ABCD, 32'h1234_5678, 32'h1800_ABCD, 32'h1234_5678, 32'h0};
    vecs[4] = '{32'h8000_0000, 32'h8000_0001, 32'h8000_0000, 32'h8000_0001, 32'h0};
    vecs[5] = '{32'h1700_FFFF, 32'hCAFE_F00D, 32'h1700_FFFF, 32'hCAFE_F00D, 32'h0};

    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    check("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_fault", {31'd0, bus.fault}, 32'd0);
    check("rst_outputs", bus.mem_addr | bus.mem_wdata | bus.instruction_out |
          bus.in_out | bus.memory_in, 32'd0);
    check("rst_state", {30'd0, bus.dbg_state}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Pass-through vectors, driven back to back
    for (int i = 0; i <= 6; i++) begin
      if (i > 0) begin
        check("pt_out_valid", {31'd0, bus.out_valid}, 32'd1);
        check("pt_instr_out", bus.instruction_out, vecs[i-1].exp_instr_out);
        check("pt_in_out", bus.in_out, vecs[i-1].exp_in_out);
        check("pt_memory_in", bus.memory_in, vecs[i-1].exp_mem_in);
        check("pt_no_req", {31'd0, bus.mem_req}, 32'd0);
      end
      if (i < 6) begin
        check("pt_ready", {31'd0, bus.in_ready}, 32'd1);
        bus.in_valid    = 1'b1;
        bus.instruction = vecs[i].instr;
        bus.alu_result  = vecs[i].alu;
        bus.store_data  = 32'h7777_7777;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
    end
    check("pt_pulse_end", {31'd0, bus.out_valid}, 32'd0);

    // Memory sequences
    mem_op("lw3", 32'h0000_AAAA, 32'h0000_0100, 32'h0, 3, 32'h8F38_FAAA, 3, 32'h8F38_FAAA, 1'b0);
    mem_op("sw1", 32'h0800_AAAA, 32'h0000_0200, 32'hF238_FAAA, 1, 32'h1111_1111, 1, 32'hF238_FAAA, 1'b0);
    mem_op("ack_last", 32'h0000_0042, 32'h0000_0300, 32'h0, TO, 32'h0BEE_F00D, TO, 32'h0BEE_F00D, 1'b0);
    mem_op("timeout", 32'h0000_0043, 32'h0000_0400, 32'h0, 0, 32'h0, TO, 32'h0, 1'b1);

    // The fault flag stays set through a later pass-through
    @(negedge clk);
    bus.in_valid    = 1'b1;
    bus.instruction = 32'h2800_0009;
    bus.alu_result  = 32'h0000_0009;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("fault_pt_valid", {31'd0, bus.out_valid}, 32'd1);
    check("fault_sticky", {31'd0, bus.fault}, 32'd1);

    // Mixed stream with an in-order expected queue. The memory acks on the first request cycle.
    begin
      int idx;
      int got;
      int cyc;
      logic [3*W-1:0] e;
      logic [W-1:0] ins;
      logic [W-1:0] alu;
      logic [W-1:0] sd;
      idx = 0; got = 0; cyc = 0;
      while ((idx < 23 || exp_q.size() > 0) && cyc < 600) begin
        @(negedge clk);
        cyc++;
        if (bus.out_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL mix_extra_out: got instr %h expected no output", bus.instruction_out);
          end else begin
            e = exp_q.pop_front();
            check("mix_instr", bus.instruction_out, e[3*W-1:2*W]);
            check("mix_in_out", bus.in_out, e[2*W-1:W]);
            check("mix_memory_in", bus.memory_in, e[W-1:0]);
            got++;
          end
        end
        bus.mem_ack   = bus.mem_req && !bus.mem_ack;
        bus.mem_rdata = bus.mem_addr ^ RK;
        if (bus.in_ready && idx < 23) begin
          ins = {ops[idx][4:0], 27'(idx * 3 + 1)};
          alu = 32'h0000_1000 + 32'(idx * 4);
          sd  = 32'hC0DE_0000 | 32'(idx);
          bus.in_valid    = 1'b1;
          bus.instruction = ins;
          bus.alu_result  = alu;
          bus.store_data  = sd;
          if (ops[idx] == 0)      exp_q.push_back({ins, alu, alu ^ RK});
          else if (ops[idx] == 1) exp_q.push_back({ins, alu, sd});
          else                    exp_q.push_back({ins, alu, 32'h0});
          idx++;
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      bus.in_valid = 1'b0;
      bus.mem_ack  = 1'b0;
      check("mix_in_budget", {31'd0, cyc < 600}, 32'd1);
      check("mix_count", got, 23);
      check("mix_fault_still", {31'd0, bus.fault}, 32'd1);
    end

    // Reset during ACCESS, then a late ack
    repeat (2) @(negedge clk);
    bus.in_valid    = 1'b1;
    bus.instruction = 32'h0000_0077;
    bus.alu_result  = 32'h0000_0500;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("mid_req_up", {31'd0, bus.mem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_req_zero", {31'd0, bus.mem_req}, 32'd0);
    check("mid_outs_zero", bus.mem_addr | bus.mem_wdata | bus.instruction_out |
          bus.in_out | bus.memory_in, 32'd0);
    check("mid_fault_clr", {31'd0, bus.fault}, 32'd0);
    check("mid_valid_zero", {31'd0, bus.out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h1234_4321;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("late_ack_valid", {31'd0, bus.out_valid}, 32'd0);
      check("late_ack_req", {31'd0, bus.mem_req}, 32'd0);
      check("late_ack_idle", {31'd0, bus.in_ready}, 32'd1);
      check("late_ack_mem_in", bus.memory_in, 32'd0);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard bound on simulated time.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
